// File: rtl/countdown_timer.sv
// Loadable down-counter with a reload register, one-shot or periodic expiry,
// and a registered one-cycle expiry pulse.
module countdown_timer #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             countEn,
  input  logic             loadEn,
  input  logic             stop,
  input  logic             periodic,
  input  logic [WIDTH-1:0] valueIn,
  output logic [WIDTH-1:0] valueOut,
  output logic             running,
  output logic             expired,
  output logic             zeroOut
);

  typedef enum logic {IDLE = 1'b0, RUNNING = 1'b1} state_e;

  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             expired_q, expired_d;

  logic [WIDTH:0]   diff_s;
  logic [WIDTH-1:0] dec_s;
  logic             borrow_s;

  // Decrement with an extra MSB: its borrow out is set only when the count is zero.
  always_comb begin
    diff_s   = {1'b0, count_q} - {{WIDTH{1'b0}}, 1'b1};
    dec_s    = diff_s[WIDTH-1:0];
    borrow_s = diff_s[WIDTH];
  end

  // Next-state logic, priority load > stop > count.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    reload_d  = reload_q;
    expired_d = 1'b0;
    if (loadEn) begin
      count_d  = valueIn;
      reload_d = valueIn;
      if (valueIn != ZERO_C) begin
        state_d = RUNNING;
      end else begin
        state_d = IDLE;
      end
    end else if (stop) begin
      state_d = IDLE;
    end else if ((state_q == RUNNING) && countEn) begin
      if (count_q == ONE_C) begin
        // Expiry edge: periodic mode is sampled only here.
        expired_d = 1'b1;
        if (periodic) begin
          count_d = reload_q;
        end else begin
          count_d = ZERO_C;
          state_d = IDLE;
        end
      end else begin
        count_d = dec_s;
      end
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= INIT;
      reload_q  <= INIT;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      expired_q <= expired_d;
    end
  end

  assign valueOut = count_q;
  assign running  = (state_q == RUNNING);
  assign expired  = expired_q;
  assign zeroOut  = borrow_s;

endmodule
